// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state type, default sizing and way-index width helper for the victim selector.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, GRANT, FILL} state_t;
  localparam int DEF_SIZE = 4;
  localparam int DEF_CNT_W = 8;
  function automatic int way_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_victim_sel.sv
// fifo_victim_sel: scans a snapshot of per-way ages one way per cycle and picks the FIFO replacement victim.
module fifo_victim_sel
  import fifo_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int CNT_W = DEF_CNT_W,
  localparam int WAY_W = way_w(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SIZE*CNT_W-1:0] age_in,
  input  logic [SIZE-1:0]       way_valid,
  output logic                  victim_valid,
  input  logic                  victim_ready,
  output logic [WAY_W-1:0]      victim_way,
  input  logic                  fill_done,
  output logic [SIZE-1:0]       write_way,
  output logic                  busy
);
  state_t state, state_d;
  logic [SIZE-1:0][CNT_W-1:0] snap_age;
  logic [SIZE-1:0] snap_valid;
  logic [WAY_W-1:0] idx, best_idx;
  logic [CNT_W-1:0] best_age;
  logic found_inv;
  logic last;
  assign last = idx == WAY_W'(SIZE - 1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign victim_valid = state == GRANT;
  assign victim_way = victim_valid ? best_idx : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state == IDLE  ? (req_valid ? SCAN : IDLE) :
              state == SCAN  ? (last ? GRANT : SCAN) :
              state == GRANT ? (victim_ready ? FILL : GRANT) :
                               (fill_done ? IDLE : FILL);
  end
  // Once an invalid way is found the search is frozen: it beats any valid way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_age <= '0;
      snap_valid <= '0;
      idx <= '0;
      best_idx <= '0;
      best_age <= '0;
      found_inv <= 1'b0;
      write_way <= '0;
    end else begin
      write_way <= (state == FILL && fill_done) ? SIZE'(1) << best_idx : '0;
      if (state == IDLE && req_valid) begin
        snap_age <= age_in;
        snap_valid <= way_valid;
        idx <= '0;
        best_idx <= '0;
        best_age <= '0;
        found_inv <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx + WAY_W'(1);
        if (!found_inv && !snap_valid[idx]) begin
          best_idx <= idx;
          found_inv <= 1'b1;
        end else if (!found_inv && snap_age[idx] > best_age) begin
          best_idx <= idx;
          best_age <= snap_age[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_victim_sel.sv
// tb_fifo_victim_sel: directed and randomized checks of victim selection, handshakes, fill pulse and reset.
module tb_fifo_victim_sel;
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready;
  logic [31:0] age_in;
  logic [3:0] way_valid;
  logic victim_valid, victim_ready;
  logic [1:0] victim_way;
  logic fill_done;
  logic [3:0] write_way;
  logic busy;
  int total = 0;
  int bad = 0;

  fifo_victim_sel #(.SIZE(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .age_in(age_in), .way_valid(way_valid), .victim_valid(victim_valid),
    .victim_ready(victim_ready), .victim_way(victim_way), .fill_done(fill_done),
    .write_way(write_way), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference: first invalid way, else first way holding the maximum age.
  function automatic int ref_victim(input logic [31:0] a, input logic [3:0] v);
    int best;
    int ages[4];
    for (int i = 0; i < 4; i++) ages[i] = int'(a[i*8 +: 8]);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    best = 0;
    for (int i = 1; i < 4; i++) if (ages[i] > ages[best]) best = i;
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic [31:0] ages, input logic [3:0] vld, input int stall, input bit hold_req);
    int exp, n, fw;
    logic [1:0] w;
    exp = ref_victim(ages, vld);
    age_in = ages;
    way_valid = vld;
    req_valid = 1'b1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL accept_ready got=%b want=1", req_ready); end
    tick();
    req_valid = hold_req;
    age_in = $urandom;
    way_valid = 4'($urandom);
    victim_ready = 1'($urandom);
    fill_done = 1'($urandom);
    n = 0;
    while (victim_valid !== 1'b1 && n < 20) begin
      total++;
      if (victim_way !== 2'd0 || req_ready !== 1'b0 || busy !== 1'b1 || write_way !== 4'd0) begin
        bad++;
        $display("FAIL scan_outputs way=%0d ready=%b busy=%b wr=%b want 0/0/1/0", victim_way, req_ready, busy, write_way);
      end
      tick();
      n++;
      age_in = $urandom;
      way_valid = 4'($urandom);
      victim_ready = 1'($urandom);
      fill_done = 1'($urandom);
    end
    victim_ready = 1'b0;
    fill_done = 1'b0;
    total++;
    if (n !== 4) begin bad++; $display("FAIL latency got=%0d want=4", n); end
    if (victim_valid !== 1'b1) return;
    total++;
    if (int'(victim_way) !== exp) begin bad++; $display("FAIL victim_way got=%0d want=%0d", victim_way, exp); end
    w = victim_way;
    for (int i = 0; i < stall; i++) begin
      fill_done = 1'($urandom);
      tick();
      total++;
      if (victim_valid !== 1'b1 || victim_way !== w || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL grant_stall valid=%b way=%0d ready=%b want 1/%0d/0", victim_valid, victim_way, req_ready, w);
      end
    end
    req_valid = 1'b0;
    fill_done = 1'b0;
    victim_ready = 1'b1;
    tick();
    victim_ready = 1'b0;
    total++;
    if (victim_valid !== 1'b0 || victim_way !== 2'd0 || busy !== 1'b1 || write_way !== 4'd0) begin
      bad++;
      $display("FAIL fill_enter valid=%b way=%0d busy=%b wr=%b want 0/0/1/0", victim_valid, victim_way, busy, write_way);
    end
    fw = $urandom_range(0, 2);
    for (int i = 0; i < fw; i++) begin
      tick();
      total++;
      if (busy !== 1'b1 || write_way !== 4'd0) begin bad++; $display("FAIL fill_wait busy=%b wr=%b want 1/0", busy, write_way); end
    end
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    total++;
    if (write_way !== 4'(1 << exp) || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL write_pulse wr=%b ready=%b busy=%b want %b/1/0", write_way, req_ready, busy, 4'(1 << exp));
    end
    tick();
    total++;
    if (write_way !== 4'd0) begin bad++; $display("FAIL write_clear got=%b want=0000", write_way); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    victim_ready = 1'b0;
    fill_done = 1'b0;
    age_in = '0;
    way_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (req_ready !== 1'b1 || victim_valid !== 1'b0 || victim_way !== 2'd0 || write_way !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdy=%b vv=%b way=%0d wr=%b busy=%b", req_ready, victim_valid, victim_way, write_way, busy);
    end
  endtask

  task automatic test_directed();
    do_txn(pack(10, 50, 30, 50), 4'b1111, 0, 1'b0);
    do_txn(pack(200, 90, 5, 255), 4'b1011, 0, 1'b0);
    do_txn(pack(0, 0, 0, 0), 4'b1111, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_txn(pack(3, 9, 1, 2), 4'b1111, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    age_in = pack(1, 2, 3, 4);
    way_valid = 4'b1111;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (req_ready !== 1'b1 || victim_valid !== 1'b0 || victim_way !== 2'd0 || write_way !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid rdy=%b vv=%b way=%0d wr=%b busy=%b", req_ready, victim_valid, victim_way, write_way, busy);
    end
    fill_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (write_way !== 4'd0 || victim_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle wr=%b vv=%b busy=%b want 0/0/0", write_way, victim_valid, busy);
      end
    end
    fill_done = 1'b0;
    do_txn(pack(7, 7, 8, 1), 4'b1111, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0] v;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++) a[i*8 +: 8] = (t % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      do_txn(a, v, $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
